tempsense_sweep_ctrl: RTL and testbench

TEMPSENSE_SWEEP_CTRL -- requirements
Module: tempsense_sweep_ctrl

---
 rtl/tempsense_sweep_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_tempsense_sweep_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tempsense_sweep_ctrl.sv
// Temperature-sensor DAC sweep controller with a Wishbone register block.
// Sweeps the DAC code downward until the delay line trips, then reports.
module tempsense_sweep_ctrl #(
   parameter int unsigned N_VDAC    = 6,
   parameter int unsigned MEAS_CYC  = 4,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_wb_cyc,
   input  logic              i_wb_stb,
   input  logic              i_wb_we,
   input  logic [31:0]       i_wb_addr,
   input  logic [31:0]       i_wb_data,
   output logic              o_wb_ack,
   output logic              o_wb_stall,
   output logic [31:0]       o_wb_data,
   output logic [N_VDAC-1:0] o_dac_data,
   output logic              o_dac_en,
   output logic              o_precharge_n,
   input  logic              i_tempdelay,
   output logic              o_irq
);

   localparam logic [N_VDAC-1:0] CODE_MAX = '1;
   localparam logic [11:0]       MEAS_END = 12'(MEAS_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_MEAS,
      S_EVAL,
      S_WAIT
   } state_t;

   state_t            state_q, state_d;
   logic [N_VDAC-1:0] code_q, code_d;
   logic [N_VDAC-1:0] result_q, result_d;
   logic [11:0]       tmr_q, tmr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              nohit_q, nohit_d;
   logic              alarm_q, alarm_d;
   logic [15:0]       cnt_q, cnt_d;

   logic              cont_q, irq_en_q;
   logic [7:0]        period_q;
   logic [5:0]        thresh_q;
   logic              ack_q, irq_q;
   logic [31:0]       rdata_q, rdata;
   logic              td_q1, td_s;

   logic              dec, wr_ctrl, wr_stat, wr_thr, start;
   logic [1:0]        sel;
   logic              fin;
   logic              unused_ok;

   assign unused_ok = ^{i_wb_data[31:16], i_wb_data[7:6], i_wb_addr[1:0]};

   assign dec     = i_wb_cyc & i_wb_stb &
                    (i_wb_addr[31:4] == BASE_ADDR[31:4]);
   assign sel     = i_wb_addr[3:2];
   assign wr_ctrl = dec & i_wb_we & (sel == 2'd0);
   assign wr_stat = dec & i_wb_we & (sel == 2'd1);
   assign wr_thr  = dec & i_wb_we & (sel == 2'd2);
   assign start   = wr_ctrl & i_wb_data[0];

   assign o_wb_ack   = ack_q;
   assign o_wb_stall = 1'b0;
   assign o_wb_data  = rdata_q;
   assign o_irq      = irq_q;

   // Sensor delay output is asynchronous to clk
   always_ff @(posedge clk) begin
      if (reset) begin
         td_q1 <= 1'b0;
         td_s  <= 1'b0;
      end else begin
         td_q1 <= i_tempdelay;
         td_s  <= td_q1;
      end
   end

   always_comb begin
      rdata = '0;
      unique case (sel)
         2'd0: begin
            rdata[1]    = cont_q;
            rdata[2]    = irq_en_q;
            rdata[15:8] = period_q;
         end
         2'd1: begin
            rdata[0]            = busy_q;
            rdata[1]            = done_q;
            rdata[2]            = nohit_q;
            rdata[3]            = alarm_q;
            rdata[8 +: N_VDAC]  = result_q;
         end
         2'd2: rdata[5:0]  = thresh_q;
         2'd3: rdata[15:0] = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ack_q    <= 1'b0;
         rdata_q  <= '0;
         cont_q   <= 1'b0;
         irq_en_q <= 1'b0;
         period_q <= '0;
         thresh_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         ack_q   <= dec;
         rdata_q <= dec ? rdata : '0;
         if (wr_ctrl) begin
            cont_q   <= i_wb_data[1];
            irq_en_q <= i_wb_data[2];
            period_q <= i_wb_data[15:8];
         end
         if (wr_thr) thresh_q <= i_wb_data[5:0];
         irq_q <= irq_en_q & (done_q | alarm_q);
      end
   end

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      result_d = result_q;
      tmr_d    = tmr_q;
      busy_d   = busy_q;
      done_d   = done_q;
      nohit_d  = nohit_q;
      alarm_d  = alarm_q;
      cnt_d    = cnt_q;
      fin      = 1'b0;

      // Clear first so a same-cycle hardware set overrides it
      if (wr_stat) begin
         if (i_wb_data[1]) done_d  = 1'b0;
         if (i_wb_data[3]) alarm_d = 1'b0;
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               code_d  = CODE_MAX;
               busy_d  = 1'b1;
               state_d = S_PRE;
            end
         end
         S_PRE: begin
            tmr_d   = '0;
            state_d = S_MEAS;
         end
         S_MEAS: begin
            if (tmr_q == MEAS_END) state_d = S_EVAL;
            else tmr_d = tmr_q + 12'd1;
         end
         S_EVAL: begin
            if (td_s) begin
               result_d = code_q;
               nohit_d  = 1'b0;
               fin      = 1'b1;
            end else if (code_q == '0) begin
               result_d = '0;
               nohit_d  = 1'b1;
               fin      = 1'b1;
            end else begin
               code_d  = code_q - 1'b1;
               state_d = S_PRE;
            end
         end
         S_WAIT: begin
            if (!cont_q) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (tmr_q == '0) begin
               code_d  = CODE_MAX;
               state_d = S_PRE;
            end else begin
               tmr_d = tmr_q - 12'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (fin) begin
         done_d = 1'b1;
         cnt_d  = cnt_q + 16'd1;
         if (!nohit_d && (32'(result_d) >= 32'(thresh_q)))
            alarm_d = 1'b1;
         if (!cont_q) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end else if (period_q == '0) begin
            code_d  = CODE_MAX;
            state_d = S_PRE;
         end else begin
            tmr_d   = {period_q, 4'b0000} - 12'd1;
            state_d = S_WAIT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         code_q   <= '0;
         result_q <= '0;
         tmr_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         nohit_q  <= 1'b0;
         alarm_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         result_q <= result_d;
         tmr_q    <= tmr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         nohit_q  <= nohit_d;
         alarm_q  <= alarm_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      o_dac_data    = CODE_MAX;
      o_dac_en      = 1'b0;
      o_precharge_n = 1'b0;
      unique case (state_q)
         S_PRE: o_dac_en = 1'b1;
         S_MEAS, S_EVAL: begin
            o_dac_data    = code_q;
            o_dac_en      = 1'b1;
            o_precharge_n = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_tempsense_sweep_ctrl.sv
// Scoreboard bench for tempsense_sweep_ctrl: reads push expected data,
// a negedge monitor pops and compares on every ack.
module tb_tempsense_sweep_ctrl;

   localparam logic [31:0] BASE = 32'h3000_0100;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_wb_cyc, i_wb_stb, i_wb_we;
   logic [31:0] i_wb_addr, i_wb_data;
   logic        o_wb_ack, o_wb_stall;
   logic [31:0] o_wb_data;
   logic [5:0]  o_dac_data;
   logic        o_dac_en, o_precharge_n;
   logic        i_tempdelay;
   logic        o_irq;

   logic        hit_en;
   logic [5:0]  hit_code;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int k = 0;

   string       nq[$];
   logic [31:0] eq[$];
   bit          cq[$];

   tempsense_sweep_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .i_wb_cyc      (i_wb_cyc),
      .i_wb_stb      (i_wb_stb),
      .i_wb_we       (i_wb_we),
      .i_wb_addr     (i_wb_addr),
      .i_wb_data     (i_wb_data),
      .o_wb_ack      (o_wb_ack),
      .o_wb_stall    (o_wb_stall),
      .o_wb_data     (o_wb_data),
      .o_dac_data    (o_dac_data),
      .o_dac_en      (o_dac_en),
      .o_precharge_n (o_precharge_n),
      .i_tempdelay   (i_tempdelay),
      .o_irq         (o_irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Sensor model: delay line trips while measuring at or below hit_code
   assign i_tempdelay = hit_en & o_dac_en & o_precharge_n &
                        (o_dac_data <= hit_code);

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      string       nm;
      logic [31:0] e;
      bit          c;
      if (o_wb_ack === 1'b1) begin
         if (nq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ack got=%h exp=no_ack", o_wb_data);
         end else begin
            nm = nq.pop_front();
            e  = eq.pop_front();
            c  = cq.pop_front();
            if (c) check(nm, o_wb_data, e);
         end
      end
   end

   task automatic bus(input logic we, input logic [7:0] off,
                      input logic [31:0] d);
      i_wb_cyc  = 1'b1;
      i_wb_stb  = 1'b1;
      i_wb_we   = we;
      i_wb_addr = BASE + 32'(off);
      i_wb_data = d;
      @(posedge clk);
      @(negedge clk);
      i_wb_cyc  = 1'b0;
      i_wb_stb  = 1'b0;
      i_wb_we   = 1'b0;
      i_wb_data = '0;
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] d);
      nq.push_back("wr");
      eq.push_back('0);
      cq.push_back(1'b0);
      bus(1'b1, off, d);
   endtask

   task automatic rd(input logic [7:0] off, input logic [31:0] exp,
                     input string nm);
      nq.push_back(nm);
      eq.push_back(exp);
      cq.push_back(1'b1);
      bus(1'b0, off, '0);
   endtask

   task automatic at(input int n);
      while (cyc < k + n) @(negedge clk);
   endtask

   initial begin
      reset     = 1'b1;
      i_wb_cyc  = 1'b0;
      i_wb_stb  = 1'b0;
      i_wb_we   = 1'b0;
      i_wb_addr = '0;
      i_wb_data = '0;
      hit_en    = 1'b0;
      hit_code  = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      check("rst_en", 32'(o_dac_en), 0);
      check("rst_dac", 32'(o_dac_data), 63);
      check("rst_pn", 32'(o_precharge_n), 0);
      check("rst_irq", 32'(o_irq), 0);
      check("rst_ack", 32'(o_wb_ack), 0);
      check("rst_rdata", o_wb_data, 0);
      rd(8'h04, 32'h0, "rst_status");
      rd(8'h00, 32'h0, "rst_ctrl");
      rd(8'h0C, 32'h0, "rst_cnt");

      // Single sweep, hit at 40
      hit_en = 1'b1;
      hit_code = 6'd40;
      wr(8'h00, 32'h1);
      k = cyc;
      at(143); rd(8'h04, 32'h0000_0001, "t1_busy");
      at(145); rd(8'h04, 32'h0000_280A, "t1_done");
      rd(8'h0C, 32'd1, "t1_cnt");
      wr(8'h04, 32'hA);
      rd(8'h04, 32'h0000_2800, "t1_w1c");

      // No hit; a second START mid-sweep is ignored
      hit_en = 1'b0;
      wr(8'h00, 32'h1);
      k = cyc;
      at(100); wr(8'h00, 32'h1);
      at(383); rd(8'h04, 32'h0000_2801, "t2_busy");
      at(385); rd(8'h04, 32'h0000_0006, "t2_nohit");
      rd(8'h0C, 32'd2, "t2_cnt");
      wr(8'h04, 32'hA);
      rd(8'h04, 32'h0000_0004, "t2_w1c");

      // Alarm and interrupt
      hit_en = 1'b1;
      hit_code = 6'd35;
      wr(8'h08, 32'd30);
      wr(8'h00, 32'h5);
      k = cyc;
      at(173); rd(8'h04, 32'h0000_0005, "t3_busy");
      check("t3_irq_lo", 32'(o_irq), 0);
      at(175); rd(8'h04, 32'h0000_230A, "t3_done");
      check("t3_irq_hi", 32'(o_irq), 1);
      wr(8'h04, 32'hA);
      check("t3_irq_hold", 32'(o_irq), 1);
      @(negedge clk);
      check("t3_irq_clr", 32'(o_irq), 0);
      rd(8'h04, 32'h0000_2300, "t3_w1c");
      rd(8'h0C, 32'd3, "t3_cnt");
      rd(8'h00, 32'h0000_0004, "t3_ctrl");
      rd(8'h08, 32'd30, "t3_thr");

      // Reset while measuring code 50
      hit_en = 1'b0;
      wr(8'h00, 32'h1);
      k = cyc;
      at(80);
      check("t5_dac50", 32'(o_dac_data), 50);
      check("t5_meas_pn", 32'(o_precharge_n), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t5_en", 32'(o_dac_en), 0);
      check("t5_dac", 32'(o_dac_data), 63);
      check("t5_pn", 32'(o_precharge_n), 0);
      check("t5_ack", 32'(o_wb_ack), 0);
      check("t5_rdata", o_wb_data, 0);
      rd(8'h04, 32'h0, "t5_status");
      rd(8'h0C, 32'h0, "t5_cnt");
      rd(8'h08, 32'h0, "t5_thr");
      bus(1'b0, 8'h10, '0);
      check("t5_noack", 32'(o_wb_ack), 0);

      // Continuous mode, PERIOD=2, hit at 20
      hit_en = 1'b1;
      hit_code = 6'd20;
      wr(8'h00, 32'h0000_0203);
      k = cyc;
      at(268); rd(8'h04, 32'h0000_140B, "t4_st1");
      at(270); rd(8'h0C, 32'd1, "t4_cnt1");
      at(280); check("t4_wait_en", 32'(o_dac_en), 0);
      at(295); check("t4_gap_end", 32'(o_dac_en), 0);
      at(296);
      check("t4_restart_en", 32'(o_dac_en), 1);
      check("t4_restart_pn", 32'(o_precharge_n), 0);
      at(566); rd(8'h0C, 32'd2, "t4_cnt2");
      at(860); rd(8'h0C, 32'd3, "t4_cnt3");
      at(900); wr(8'h00, 32'h0);
      at(1140); rd(8'h04, 32'h0000_140B, "t4_still_busy");
      at(1160); rd(8'h04, 32'h0000_140A, "t4_stopped");
      rd(8'h0C, 32'd4, "t4_cnt4");

      repeat (3) @(negedge clk);
      check("drain", 32'(nq.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
